// File: rtl/raminfr_pkg.sv
// Shared constants for the parametrised dual-port synchronous RAM family.
package raminfr_pkg;

  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // True when a same-cycle write must be forwarded to a colliding read.
  function automatic logic rdw_forward(input int unsigned mode, input logic wr, input logic hit);
    return (mode == RDW_WRITE_FIRST) && wr && hit;
  endfunction

endpackage

// File: rtl/raminfr_rd_pipe.sv
// Read-data pipeline for one RAM port: synchronous read stage plus optional output register.
module raminfr_rd_pipe #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] raw,
  input  logic              raw_valid,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;

  // First stage captures the array output only on an accepted read, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= raw_valid;
      if (raw_valid) begin
        s1_data <= raw;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          data  <= '0;
          valid <= 1'b0;
        end else begin
          valid <= s1_valid;
          if (s1_valid) begin
            data <= s1_data;
          end
        end
      end
    end else begin : g_no_out_reg
      assign data  = s1_data;
      assign valid = s1_valid;
    end
  endgenerate

endmodule

// File: rtl/raminfr_dp_sync.sv
// Dual-port RAM: port A read/write, port B read-only, synchronous reads, reset-driven clear sweep.
module raminfr_dp_sync
  import raminfr_pkg::*;
#(
  parameter int unsigned DATA_W         = 4,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] spo,
  output logic              spo_valid,
  input  logic              dpre,
  input  logic [ADDR_W-1:0] dpra,
  output logic [DATA_W-1:0] dpo,
  output logic              dpo_valid,
  output logic              init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] clr_addr_next;
  logic              clr_we_c;
  logic              idle_c;
  logic              wr_en_c;
  logic              rd_a_c;
  logic              rd_b_c;
  logic [DATA_W-1:0] raw_a_c;
  logic [DATA_W-1:0] raw_b_c;

  // Clear sequencer state register; a reset mid-sweep restarts from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr  <= '0;
      init_busy <= (CLEAR_ON_RESET != 0);
    end else begin
      state     <= state_next;
      clr_addr  <= clr_addr_next;
      init_busy <= (state_next == ST_CLEAR);
    end
  end

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    clr_we_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_CLEAR: begin
        clr_we_c      = 1'b1;
        clr_addr_next = clr_addr + ADDR_W'(1);
        if (clr_addr == LAST_ADDR) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Requests are honoured only in normal operation and never on a reset edge.
  assign idle_c  = (state == ST_IDLE) && !rst;
  assign wr_en_c = idle_c && we;
  assign rd_a_c  = idle_c && re;
  assign rd_b_c  = idle_c && dpre;

  // Port A always collides with its own write; port B only when addresses match.
  assign raw_a_c = rdw_forward(RDW_MODE, wr_en_c, 1'b1)         ? di : mem[a];
  assign raw_b_c = rdw_forward(RDW_MODE, wr_en_c, (dpra == a))  ? di : mem[dpra];

  always_ff @(posedge clk) begin
    if (clr_we_c && !rst) begin
      mem[clr_addr] <= '0;
    end else if (wr_en_c) begin
      mem[a] <= di;
    end
  end

  raminfr_rd_pipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw_a_c),
    .raw_valid (rd_a_c),
    .data      (spo),
    .valid     (spo_valid)
  );

  raminfr_rd_pipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw_b_c),
    .raw_valid (rd_b_c),
    .data      (dpo),
    .valid     (dpo_valid)
  );

endmodule

// File: doc/raminfr_dp_sync.md
Name: raminfr_dp_sync

Overview:
Parametrised successor to the team's 32x4 dual-port distributed RAM. Port A reads and writes; port B is read-only. Both read ports are truly synchronous, with an optional output register and per-port valid flags. Read-during-write behaviour is selectable, and a reset-triggered clear sequencer zeroes the array. It is a drop-in buffer for the datapath, FIFO and scratchpad blocks.

Parameters:
- DATA_W, 4, data word width (>=1)
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W, derived, not overridable
- OUT_REG, 0, 0: read latency 1; 1: extra output register, latency 2
- RDW_MODE, 0, 0: WRITE_FIRST; 1: READ_FIRST; applies to both ports on an address collision
- CLEAR_ON_RESET, 1, 1: reset launches a full-array zero sweep; 0: contents untouched by reset

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  port A write enable
- re  in  1  port A read enable
- a  in  ADDR_W  port A address
- di  in  DATA_W  port A write data
- spo  out  DATA_W  port A read data
- spo_valid  out  1  spo carries a new read result this cycle
- dpre  in  1  port B read enable
- dpra  in  ADDR_W  port B address
- dpo  out  DATA_W  port B read data
- dpo_valid  out  1  dpo carries a new read result this cycle
- init_busy  out  1  clear sweep in progress; requests are ignored

Behaviour:
- Reset (rst high at an edge):
  - spo, dpo, all pipeline registers = 0; spo_valid, dpo_valid = 0.
  - CLEAR_ON_RESET=1: FSM enters CLEAR, clr_addr=0, init_busy=1.
  - CLEAR_ON_RESET=0: FSM enters IDLE, init_busy=0.
- FSM states and transitions:
  - IDLE: normal operation.
  - CLEAR: each cycle writes 0 to mem[clr_addr] and increments clr_addr.
  - After the write to DEPTH-1, go to IDLE. clr_addr wraps to 0.
  - init_busy is high for exactly DEPTH cycles after the first cycle with rst low.
  - rst reasserted mid-sweep restarts the sweep at address 0.
- During CLEAR:
  - we, re, dpre are ignored; no memory writes from port A.
  - Valids stay 0; spo and dpo hold their value.
- Write: in IDLE with we=1 at an edge, mem[a] <= di.
- Port A read:
  - re=1 at edge N: spo updates, with spo_valid=1 for one cycle, at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
  - Back-to-back reads are fully pipelined, one result per cycle.
  - When no read completes, spo holds its last value and spo_valid=0.
- Port B read: identical timing, driven by dpre and dpra into dpo and dpo_valid; independent of port A.
- Collision (we=1 and a read of the same address in the same cycle):
  - WRITE_FIRST: the result is di.
  - READ_FIRST: the result is the prior contents.
  - Applies to port A (we&re) and port B (we&dpre&dpra==a).
- Different-address simultaneous accesses: no interaction.
- Latency pipeline and valid pipeline flush to 0 on rst. A read issued in the cycle rst is high is discarded.
- Addresses always lie in range (DEPTH = 2**ADDR_W); no bounds checking.
- Contents with CLEAR_ON_RESET=0 before the first write: undefined (X in simulation); the bench does not check them.

Decomposition:
- Package raminfr_pkg:
  - RDW_WRITE_FIRST=0, RDW_READ_FIRST=1
  - FSM state encodings ST_IDLE, ST_CLEAR
- Sub-module raminfr_rd_pipe (params DATA_W, OUT_REG):
  - Takes raw data and a valid flag; applies the optional output register; holds data when not valid.
  - Instantiated once per read port.
- Array, write logic, collision mux and clear FSM live in the top.

Test Plan (defaults DATA_W=4, ADDR_W=5 unless stated):
- Clear sweep: pulse rst 1 cycle. Required: init_busy high for 32 cycles, then low. A subsequent read of addresses 0, 17 and 31 returns 0000 on both ports.
- Basic write/read: write a=1 di=1010, then a=2 di=1100. Read re a=1 and dpre dpra=2 in the same cycle. Required: one edge later spo=1010, dpo=1100, both valids=1 for one cycle. With OUT_REG=1, the same results arrive two edges later.
- Collision: mem[3]=0101; in one cycle we=1 a=3 di=1111, re=1, dpre=1 dpra=3.
  - RDW_MODE=0: spo=dpo=1111.
  - RDW_MODE=1: spo=dpo=0101.
  - In both modes, a later read of address 3 returns 1111.
- Ignore while busy: during the clear sweep drive we=1 a=5 di=1001, re=1, dpre=1. Required: valids stay 0, and after the sweep mem[5] reads 0000.
- Reset mid-operation:
  - re=1 issued, then rst asserted next cycle (OUT_REG=1). Required: spo_valid never asserts, spo=0000.
  - rst pulsed at sweep cycle 10. Required: init_busy then stays high for a further 32 cycles.
- Streaming: 32 consecutive reads on port B, addresses 0..31, after writing mem[i]=i[3:0]. Required: dpo_valid high for 32 consecutive cycles with data i[3:0] in order, then dpo_valid=0 and dpo holds 1111.
